// File: rtl/cp0_exc.sv
// cp0_exc: coprocessor-0 exception unit at the M stage.
// It decides whether an exception or interrupt is taken.
// It records Cause, EPC and SR.EXL, and serves mfc0, mtc0 and eret.
// Optional Count/Compare timer: define CP0_TIMER_EN.
module cp0_exc #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic [31:0] pc_m,
  input  logic [4:0]  exccode_m,
  input  logic        bd_m,
  input  logic        eret_m,
  input  logic [5:0]  hwint,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc,
  output logic [31:0] dout
);

  // SR fields
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  // Cause fields
  logic        cause_bd;
  logic [5:0]  cause_ip_q;
  logic [4:0]  cause_exc;
  // EPC word address (low two bits are always zero)
  logic [29:0] epc_q;

  logic        timer_ip;
  logic [5:0]  ip_now;
  logic [5:0]  ip_next;
  logic        int_req;
  logic        exc_req;
  logic        wr_en;
  logic [31:0] epc_calc;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] count_inc;
  logic        tip;

  assign count_inc = count_q + 32'd1;
  assign timer_ip  = tip;

  // Count/Compare timer; a Count write overrides the increment, a Compare write clears TIP.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      tip       <= 1'b0;
    end else begin
      if (wr_en && addr == 5'd9) begin
        count_q <= din;
      end else begin
        count_q <= count_inc;
      end
      if (wr_en && addr == 5'd11) begin
        compare_q <= din;
        tip       <= 1'b0;
      end else if (!(wr_en && addr == 5'd9) && count_inc == compare_q) begin
        tip <= 1'b1;
      end
    end
  end
`else
  assign timer_ip = 1'b0;
`endif

  // IP as read back, and IP including the live hwint for the request decision
  assign ip_now  = {cause_ip_q[5] | timer_ip, cause_ip_q[4:0]};
  assign ip_next = {hwint[5] | timer_ip, hwint[4:0]};

  assign int_req = sr_ie & ~sr_exl & (|(ip_next & sr_im));
  assign exc_req = (exccode_m != 5'd0) & ~sr_exl;
  assign req     = ~reset & (int_req | exc_req);

  // A cancelled M instruction must not commit its mtc0
  assign wr_en    = we & ~req;
  assign epc_calc = bd_m ? (pc_m - 32'd4) : pc_m;

  assign handler_pc = HANDLER_ADDR;
  assign epc        = {epc_q, 2'b00};

  // Architectural state: exception entry, mtc0 writes, eret, IP sampling
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im      <= '0;
      sr_exl     <= 1'b0;
      sr_ie      <= 1'b0;
      cause_bd   <= 1'b0;
      cause_ip_q <= '0;
      cause_exc  <= '0;
      epc_q      <= '0;
    end else begin
      cause_ip_q <= hwint;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : exccode_m;
        cause_bd  <= bd_m;
        epc_q     <= epc_calc[31:2];
      end else begin
        if (we && addr == 5'd12) begin
          sr_im  <= din[15:10];
          sr_exl <= din[1];
          sr_ie  <= din[0];
        end
        if (we && addr == 5'd14) begin
          epc_q <= din[31:2];
        end
        if (eret_m) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read mux from pre-update register values
  always_comb begin
    dout = '0;
    case (addr)
`ifdef CP0_TIMER_EN
      5'd9:  dout = count_q;
      5'd11: dout = compare_q;
`endif
      5'd12: dout = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      5'd13: dout = {cause_bd, 15'd0, ip_now, 3'd0, cause_exc, 2'b00};
      5'd14: dout = {epc_q, 2'b00};
      5'd15: dout = PRID_VAL;
      default: dout = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{din[31:16], din[9:2], epc_calc[1:0]};

endmodule

// File: tb/tb_cp0_exc.sv
// tb_cp0_exc: directed, self-checking bench for cp0_exc.
// Timer checks are compiled in when CP0_TIMER_EN is defined.
module tb_cp0_exc;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] pc_m;
  logic [4:0]  exccode_m;
  logic        bd_m;
  logic        eret_m;
  logic [5:0]  hwint;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc;
  logic [31:0] dout;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  cp0_exc #(.HANDLER_ADDR(32'h0000_4180), .PRID_VAL(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .din(din),
    .pc_m(pc_m), .exccode_m(exccode_m), .bd_m(bd_m), .eret_m(eret_m),
    .hwint(hwint), .req(req), .handler_pc(handler_pc), .epc(epc), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then return inputs to idle (except hwint/reset)
  task automatic tick();
    @(posedge clk);
    #1;
    we = 1'b0; addr = 5'd0; din = '0; exccode_m = '0; bd_m = 1'b0;
    eret_m = 1'b0; pc_m = '0;
  endtask

  task automatic check_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; din = d;
    tick();
  endtask

  task automatic check_req(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, req}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; din = '0; pc_m = '0; exccode_m = '0;
    bd_m = 1'b0; eret_m = 1'b0; hwint = '0;
    tick(); tick();
    check_req("reset_req", 1'b0);
    check("reset_epc", epc, 32'h0);
    check_rd("reset_sr", 5'd12, 32'h0);
    check("handler_pc", handler_pc, 32'h0000_4180);
    reset = 1'b0;
    tick();

    // RI exception
    mtc0(5'd12, 32'h0000_FC01);
    check_rd("sr_write", 5'd12, 32'h0000_FC01);
    exccode_m = 5'd10; pc_m = 32'h3010;
    check_req("ri_req", 1'b1);
    tick();
    check_rd("ri_cause", 5'd13, 32'h0000_0028);
    check_rd("ri_epc", 5'd14, 32'h0000_3010);
    check_rd("ri_sr", 5'd12, 32'h0000_FC03);
    check("ri_epc_port", epc, 32'h0000_3010);

    // Masked while EXL = 1
    exccode_m = 5'd10; pc_m = 32'h5000;
    check_req("exl_mask_req", 1'b0);
    tick();
    check_rd("exl_mask_epc", 5'd14, 32'h0000_3010);
    check_rd("exl_mask_cause", 5'd13, 32'h0000_0028);
    eret_m = 1'b1;
    check_req("eret_exl_req", 1'b0);
    tick();
    check_rd("eret_sr", 5'd12, 32'h0000_FC01);

    // Delay-slot exception
    exccode_m = 5'd12; bd_m = 1'b1; pc_m = 32'h3024;
    check_req("bd_req", 1'b1);
    tick();
    check_rd("bd_epc", 5'd14, 32'h0000_3020);
    check_rd("bd_cause", 5'd13, 32'h8000_0030);
    eret_m = 1'b1;
    tick();

    // Interrupt beats simultaneous exception
    hwint = 6'b000001; exccode_m = 5'd4; pc_m = 32'h4000;
    check_req("int_req", 1'b1);
    tick();
    check_rd("int_cause", 5'd13, 32'h0000_0400);
    check_rd("int_epc", 5'd14, 32'h0000_4000);
    check_req("int_exl_mask", 1'b0);
    eret_m = 1'b1;
    tick();
    check_req("int_after_eret", 1'b1);
    hwint = 6'b000000;
    check_req("int_dropped", 1'b0);

    // mtc0 EPC low bits forced to zero
    mtc0(5'd14, 32'h0000_3103);
    check_rd("epc_align", 5'd14, 32'h0000_3100);
    check("epc_align_port", epc, 32'h0000_3100);

    // mtc0 SR dropped when req fires
    we = 1'b1; addr = 5'd12; din = 32'h0000_0001; exccode_m = 5'd10; pc_m = 32'h6000;
    check_req("mtc0_req", 1'b1);
    tick();
    check_rd("mtc0_dropped_sr", 5'd12, 32'h0000_FC03);
    check_rd("mtc0_req_epc", 5'd14, 32'h0000_6000);
    eret_m = 1'b1;
    tick();

    // IM / IE masking
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000010;
    check_req("im_masked", 1'b0);
    hwint = 6'b000001;
    check_req("im_enabled", 1'b1);
    hwint = 6'b000000;
    mtc0(5'd12, 32'h0000_FC00);
    hwint = 6'b000001;
    check_req("ie_off", 1'b0);
    hwint = 6'b000000;

    // Read-only and unimplemented registers
    mtc0(5'd13, 32'hFFFF_FFFF);
    check_rd("cause_ro", 5'd13, 32'h0000_0028);
    check_rd("prid", 5'd15, 32'h0000_0000);
    check_rd("reg0", 5'd0, 32'h0000_0000);
`ifndef CP0_TIMER_EN
    mtc0(5'd9, 32'h1234_5678);
    check_rd("count_off", 5'd9, 32'h0);
    check_rd("compare_off", 5'd11, 32'h0);
`endif

    // Reset during handler clears EXL and holds req low
    exccode_m = 5'd10; pc_m = 32'h7000;
    tick();
    check_rd("pre_reset_sr", 5'd12, 32'h0000_FC02);
    reset = 1'b1; exccode_m = 5'd10;
    check_req("reset_hold_req", 1'b0);
    tick();
    check_rd("reset_sr2", 5'd12, 32'h0);
    check_rd("reset_epc2", 5'd14, 32'h0);
    check_rd("reset_cause2", 5'd13, 32'h0);
    reset = 1'b0;
    tick();

`ifdef CP0_TIMER_EN
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'h0000_0005);
    mtc0(5'd9, 32'h0000_0000);
    check_rd("count_zero", 5'd9, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check_req("timer_early", 1'b0);
    tick();
    check_rd("count_five", 5'd9, 32'h5);
    check_req("timer_req", 1'b1);
    tick();
    check_rd("timer_cause", 5'd13, 32'h0000_8000);
    mtc0(5'd11, 32'h0000_0005);
    check_rd("tip_cleared", 5'd13, 32'h0000_0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
